data_sram_responder: RTL and testbench

Responder (slave) end of the single-cycle CPU's data SRAM port: it accepts the CPU's word-wide `data_sram_*` requests and answers them from a local word RAM plus a small memory-mapped peripheral page (LED, switches, free-running timer, scratch). Reads are combinational, so the CPU's load result is available in the same cycle as the address. Writes commit on the next rising clock edge. The block sits beside the CPU top level in the SoC wrapper and replaces the bare data RAM.

---
 rtl/data_sram_responder.sv | 94 +++++++++
 tb/tb_data_sram_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Responder end of the CPU data SRAM port. Serves word accesses from a local
//   word RAM and a small peripheral page (LED, switches, timer, scratch).
//   Reads are combinational from the address. Writes commit on the rising edge.
// Ports:
//   clk, reset          - rising-edge clock, async active-high reset
//   data_sram_we        - 1 = write this cycle, 0 = read
//   data_sram_addr      - byte address, bits [1:0] ignored
//   data_sram_wdata     - write data
//   data_sram_rdata     - combinational read data
//   led                 - LED register contents
//   sw                  - asynchronous switch inputs (2-flop synchronized)
module data_sram_responder #(
  parameter int RAM_AW = 10,
  parameter int LED_W  = 16,
  parameter int SW_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_sram_we,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   sw
);

  localparam logic [15:0] OFF_LED     = 16'h8000;
  localparam logic [15:0] OFF_SW      = 16'h8004;
  localparam logic [15:0] OFF_TIMER   = 16'h8008;
  localparam logic [15:0] OFF_SCRATCH = 16'h800C;

  logic [31:0]       r_ram [0:(2**RAM_AW)-1];
  logic [LED_W-1:0]  r_led;
  logic [31:0]       r_timer;
  logic [31:0]       r_scratch;
  logic [SW_W-1:0]   r_sw_s1;
  logic [SW_W-1:0]   r_sw_s2;

  logic              w_ram_hit;
  logic              w_per_hit;
  logic [RAM_AW-1:0] w_idx;
  logic [15:0]       w_off;
  logic              w_sel_led;
  logic              w_sel_sw;
  logic              w_sel_timer;
  logic              w_sel_scratch;

  assign w_ram_hit     = (data_sram_addr[31:RAM_AW+2] == '0);
  assign w_per_hit     = (data_sram_addr[31:16] == 16'hBFAF);
  assign w_idx         = data_sram_addr[RAM_AW+1:2];
  // Byte-lane bits are masked off so any byte address within a word selects it.
  assign w_off         = data_sram_addr[15:0] & 16'hFFFC;
  assign w_sel_led     = w_per_hit && (w_off == OFF_LED);
  assign w_sel_sw      = w_per_hit && (w_off == OFF_SW);
  assign w_sel_timer   = w_per_hit && (w_off == OFF_TIMER);
  assign w_sel_scratch = w_per_hit && (w_off == OFF_SCRATCH);

  // RAM has no reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && data_sram_we && w_ram_hit)
      r_ram[w_idx] <= data_sram_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led     <= '0;
      r_timer   <= '0;
      r_scratch <= '0;
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      if (data_sram_we && w_sel_led)     r_led     <= data_sram_wdata[LED_W-1:0];
      if (data_sram_we && w_sel_scratch) r_scratch <= data_sram_wdata;
      // A write to the timer overrides that cycle's increment.
      if (data_sram_we && w_sel_timer)   r_timer   <= data_sram_wdata;
      else                               r_timer   <= r_timer + 32'd1;
    end
  end

  always_comb begin
    data_sram_rdata = 32'h0;
    if (w_ram_hit)          data_sram_rdata = r_ram[w_idx];
    else if (w_sel_led)     data_sram_rdata = 32'(r_led);
    else if (w_sel_sw)      data_sram_rdata = 32'(r_sw_s2);
    else if (w_sel_timer)   data_sram_rdata = r_timer;
    else if (w_sel_scratch) data_sram_rdata = r_scratch;
  end

  assign led = r_led;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [7:0]  sw;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.RAM_AW(10), .LED_W(16), .SW_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .led             (led),
    .sw              (sw)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
  } vec_t;

  vec_t v [21];

  localparam logic [31:0] A_LED  = 32'hBFAF_8000;
  localparam logic [31:0] A_SW   = 32'hBFAF_8004;
  localparam logic [31:0] A_TMR  = 32'hBFAF_8008;
  localparam logic [31:0] A_SCR  = 32'hBFAF_800C;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance one edge and return to the middle of the low phase.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    we = w; addr = a; wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we    addr          wdata          chk   exp_rd         exp_led
    v[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0,         16'h0};
    v[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h1234_5678, 16'h0};
    v[2]  = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h1234_5678, 16'h0};
    v[3]  = '{1'b1, 32'h0000_0010, 32'hAAAA_AAAA, 1'b1, 32'h1234_5678, 16'h0};
    v[4]  = '{1'b1, 32'h0000_0010, 32'h5555_5555, 1'b1, 32'hAAAA_AAAA, 16'h0};
    v[5]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h5555_5555, 16'h0};
    v[6]  = '{1'b1, A_LED,         32'hFFFF_00A5, 1'b1, 32'h0,         16'h0};
    v[7]  = '{1'b0, A_LED,         32'h0,         1'b1, 32'h0000_00A5, 16'h00A5};
    v[8]  = '{1'b1, A_SCR,         32'h0000_0007, 1'b1, 32'h0,         16'h00A5};
    v[9]  = '{1'b0, A_SCR,         32'h0,         1'b1, 32'h0000_0007, 16'h00A5};
    v[10] = '{1'b1, A_SW,          32'hDEAD_BEEF, 1'b1, 32'h0,         16'h00A5};
    v[11] = '{1'b0, A_SW,          32'h0,         1'b1, 32'h0,         16'h00A5};
    v[12] = '{1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 1'b1, 32'h0,         16'h00A5};
    v[13] = '{1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0,         16'h00A5};
    v[14] = '{1'b1, 32'hBFAF_8010, 32'hDEAD_BEEF, 1'b1, 32'h0,         16'h00A5};
    v[15] = '{1'b0, 32'hBFAF_8010, 32'h0,         1'b1, 32'h0,         16'h00A5};
    v[16] = '{1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 1'b1, 32'h0,         16'h00A5};
    v[17] = '{1'b0, A_LED,         32'h0,         1'b1, 32'h0000_00A5, 16'h00A5};
    v[18] = '{1'b0, A_SCR,         32'h0,         1'b1, 32'h0000_0007, 16'h00A5};
    v[19] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h5555_5555, 16'h00A5};
    v[20] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0,         16'h00A5};

    reset = 1'b1; sw = 8'h0;
    drive(1'b0, A_LED, 32'h0);
    #1;
    chk("rst_led_rd", rdata, 32'h0);
    chk("rst_led_out", 32'(led), 32'h0);
    addr = A_TMR; #1;
    chk("rst_timer_rd", rdata, 32'h0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("post_rst_timer0", rdata, 32'h0);
    tick(); #1;
    chk("post_rst_timer1", rdata, 32'h1);

    // table-driven main function
    for (int i = 0; i < 21; i++) begin
      drive(v[i].we, v[i].addr, v[i].wdata);
      #1;
      if (v[i].chk_rd) chk($sformatf("vec%0d_rd", i), rdata, v[i].exp_rd);
      chk($sformatf("vec%0d_led", i), 32'(led), 32'(v[i].exp_led));
      tick();
    end

    // switch synchronizer: visible two edges after the change
    drive(1'b0, A_SW, 32'h0);
    sw = 8'h3C; #1;
    chk("sw_edge0", rdata, 32'h0);
    tick(); #1;
    chk("sw_edge1", rdata, 32'h0);
    tick(); #1;
    chk("sw_edge2", rdata, 32'h0000_003C);

    // timer load and wrap
    drive(1'b1, A_TMR, 32'hFFFF_FFFE);
    tick();
    drive(1'b0, A_TMR, 32'h0); #1;
    chk("tmr_load", rdata, 32'hFFFF_FFFE);
    tick(); #1;
    chk("tmr_ffff", rdata, 32'hFFFF_FFFF);
    tick(); #1;
    chk("tmr_wrap0", rdata, 32'h0);
    tick(); #1;
    chk("tmr_wrap1", rdata, 32'h1);
    tick();

    // async reset mid-run
    drive(1'b1, A_LED, 32'h0000_00F0); tick();
    drive(1'b1, A_SCR, 32'h0000_0007); tick();
    drive(1'b1, A_TMR, 32'h0000_0100); tick();
    drive(1'b0, A_TMR, 32'h0); #1;
    chk("pre_rst_timer", rdata, 32'h0000_0100);
    chk("pre_rst_led", 32'(led), 32'h0000_00F0);
    reset = 1'b1; #1;
    chk("async_timer", rdata, 32'h0);
    chk("async_led_out", 32'(led), 32'h0);
    addr = A_SCR; #1;
    chk("async_scratch", rdata, 32'h0);
    addr = A_LED; #1;
    chk("async_led_rd", rdata, 32'h0);
    // writes across an edge while reset is held must be lost
    drive(1'b1, 32'h0000_0010, 32'h1111_1111);
    tick();
    drive(1'b1, A_SCR, 32'h0000_0099);
    tick();
    reset = 1'b0;
    drive(1'b0, A_TMR, 32'h0); #1;
    chk("rel_timer0", rdata, 32'h0);
    tick(); #1;
    chk("rel_timer1", rdata, 32'h1);
    addr = A_SCR; #1;
    chk("rel_scratch", rdata, 32'h0);
    addr = 32'h0000_0010; #1;
    chk("ram_kept", rdata, 32'h5555_5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
